leb128_decoder: RTL and testbench

LEB128_DECODER -- requirements
Module: leb128_decoder

---
 rtl/leb128_decoder.sv | 146 ++++++++++++++
 tb/tb_leb128_decoder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/leb128_decoder.sv
// LEB128 decoder: assembles a signed or unsigned LEB128 byte stream
// into a WIDTH-bit value using valid/ready handshakes on both sides.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_byte/in_valid      next encoded byte, bit 7 = continuation
//   in_ready              decoder can take a byte (ACCUM state)
//   is_signed             decode mode, sampled with byte 0 of a value
//   result/result_valid   decoded value, held until result_ready
//   result_ready          consumer takes the result
//   bytes_used            bytes consumed for the current value
//   trap                  0 none, 1 too long, 2 bad final-byte bits
module leb128_decoder #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       in_byte,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             is_signed,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [3:0]       bytes_used,
    output logic [2:0]       trap
);

    localparam int MAX_BYTES = (WIDTH + 6) / 7;
    // payload bits of the last byte that still land inside the result
    localparam int LAST_BITS = WIDTH - 7 * (MAX_BYTES - 1);
    localparam logic [3:0] LAST_IDX = 4'(MAX_BYTES - 1);
    localparam logic [6:0] TOP_ONES = 7'h7f >> (LAST_BITS - 1);

    typedef enum logic [1:0] {
        ACCUM,
        DONE,
        ERROR
    } state_t;

    state_t           r_state, w_state_n;
    logic [WIDTH-1:0] r_acc, w_acc_n;
    logic [3:0]       r_cnt, w_cnt_n;
    logic             r_signed, w_signed_n;
    logic [2:0]       r_trap, w_trap_n;

    logic [6:0]       w_payload;
    logic             w_last;
    logic             w_sgn;
    logic [6:0]       w_sh_lo;
    logic [6:0]       w_sh_hi;
    logic [WIDTH-1:0] w_shifted;
    logic [WIDTH-1:0] w_acc;
    logic [WIDTH-1:0] w_ext;
    logic [WIDTH-1:0] w_final;
    logic [6:0]       w_hi_u;
    logic [6:0]       w_hi_s;
    logic             w_bad_top;

    assign w_payload = in_byte[6:0];
    assign w_last    = (r_cnt == LAST_IDX);
    // mode comes live from the port only for byte 0
    assign w_sgn     = (r_cnt == 4'd0) ? is_signed : r_signed;
    assign w_sh_lo   = 7'(r_cnt) * 7'd7;
    assign w_sh_hi   = w_sh_lo + 7'd7;
    // shifting past WIDTH drops the excess payload bits
    assign w_shifted = {{(WIDTH-7){1'b0}}, w_payload} << w_sh_lo;
    assign w_acc     = r_acc | w_shifted;
    // all-zero on the last byte since w_sh_hi >= WIDTH there
    assign w_ext     = {WIDTH{1'b1}} << w_sh_hi;
    assign w_final   = (w_sgn && w_payload[6]) ? (w_acc | w_ext) : w_acc;

    // bits of the last byte above the result must be a clean extension
    assign w_hi_u    = w_payload >> LAST_BITS;
    assign w_hi_s    = w_payload >> (LAST_BITS - 1);
    assign w_bad_top = w_last && (w_sgn
                     ? (w_hi_s != 7'd0 && w_hi_s != TOP_ONES)
                     : (w_hi_u != 7'd0));

    always_comb begin
        w_state_n  = r_state;
        w_acc_n    = r_acc;
        w_cnt_n    = r_cnt;
        w_signed_n = r_signed;
        w_trap_n   = r_trap;
        unique case (r_state)
            ACCUM: begin
                if (in_valid) begin
                    if (r_cnt == 4'd0) begin
                        w_signed_n = is_signed;
                    end
                    if (in_byte[7] && w_last) begin
                        w_state_n = ERROR;
                        w_trap_n  = 3'd1;
                    end else if (in_byte[7]) begin
                        w_acc_n = w_acc;
                        w_cnt_n = r_cnt + 4'd1;
                    end else if (w_bad_top) begin
                        w_state_n = ERROR;
                        w_trap_n  = 3'd2;
                    end else begin
                        w_acc_n   = w_final;
                        w_cnt_n   = r_cnt + 4'd1;
                        w_state_n = DONE;
                    end
                end
            end
            DONE: begin
                if (result_ready) begin
                    w_acc_n   = '0;
                    w_cnt_n   = 4'd0;
                    w_state_n = ACCUM;
                end
            end
            ERROR: begin
                w_state_n = ERROR;
            end
            default: begin
                w_state_n = ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ACCUM;
            r_acc    <= '0;
            r_cnt    <= 4'd0;
            r_signed <= 1'b0;
            r_trap   <= 3'd0;
        end else begin
            r_state  <= w_state_n;
            r_acc    <= w_acc_n;
            r_cnt    <= w_cnt_n;
            r_signed <= w_signed_n;
            r_trap   <= w_trap_n;
        end
    end

    assign in_ready     = (r_state == ACCUM);
    assign result_valid = (r_state == DONE);
    assign result       = r_acc;
    assign bytes_used   = r_cnt;
    assign trap         = r_trap;

endmodule

// File: tb/tb_leb128_decoder.sv
// Directed bench for leb128_decoder: a vector table on a 32-bit
// instance plus hand sequences for handshake, reset and 64-bit cases.
module tb_leb128_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 32-bit instance
    logic        rst, iv, isg, rr, ir, rv;
    logic [7:0]  ib;
    logic [31:0] res;
    logic [3:0]  used;
    logic [2:0]  trap;

    // 64-bit instance
    logic        rst6, iv6, isg6, rr6, ir6, rv6;
    logic [7:0]  ib6;
    logic [63:0] res6;
    logic [3:0]  used6;
    logic [2:0]  trap6;

    leb128_decoder #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(rst), .in_byte(ib), .in_valid(iv),
        .in_ready(ir), .is_signed(isg), .result(res),
        .result_valid(rv), .result_ready(rr),
        .bytes_used(used), .trap(trap)
    );

    leb128_decoder #(.WIDTH(64)) dut64 (
        .clk(clk), .reset(rst6), .in_byte(ib6), .in_valid(iv6),
        .in_ready(ir6), .is_signed(isg6), .result(res6),
        .result_valid(rv6), .result_ready(rr6),
        .bytes_used(used6), .trap(trap6)
    );

    typedef struct {
        logic        sgn;
        int          n;
        logic [79:0] bs;    // right-aligned, first byte most significant
        logic [63:0] res;
        int          used;
        logic [2:0]  trap;
    } vec_t;

    vec_t vt[12];

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic reset32();
        @(negedge clk);
        rst = 1'b1; iv = 1'b0; rr = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic reset64();
        @(negedge clk);
        rst6 = 1'b1; iv6 = 1'b0; rr6 = 1'b0;
        @(negedge clk);
        rst6 = 1'b0;
    endtask

    // ends at the negedge one cycle after the last byte is accepted
    task automatic feed32(input logic sgn, input int n,
                          input logic [79:0] bs);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ib = bs[8*(n-1-i) +: 8]; iv = 1'b1; isg = sgn;
        end
        @(negedge clk);
        iv = 1'b0; ib = 8'h00;
    endtask

    task automatic feed64(input logic sgn, input int n,
                          input logic [79:0] bs);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ib6 = bs[8*(n-1-i) +: 8]; iv6 = 1'b1; isg6 = sgn;
        end
        @(negedge clk);
        iv6 = 1'b0; ib6 = 8'h00;
    endtask

    task automatic setv(input int k, input logic sgn, input int n,
                        input logic [79:0] bs, input logic [63:0] r,
                        input int u, input logic [2:0] t);
        vt[k].sgn = sgn; vt[k].n = n; vt[k].bs = bs;
        vt[k].res = r; vt[k].used = u; vt[k].trap = t;
    endtask

    initial begin
        rst = 1'b1; iv = 1'b0; isg = 1'b0; rr = 1'b0; ib = 8'h00;
        rst6 = 1'b1; iv6 = 1'b0; isg6 = 1'b0; rr6 = 1'b0; ib6 = 8'h00;

        setv(0,  1'b1, 1, 80'h2A,         64'd42,         1, 3'd0);
        setv(1,  1'b1, 1, 80'h7F,         64'hFFFFFFFF,   1, 3'd0);
        setv(2,  1'b0, 3, 80'hE58E26,     64'd624485,     3, 3'd0);
        setv(3,  1'b0, 5, 80'h8080808080, 64'd0,          0, 3'd1);
        setv(4,  1'b0, 5, 80'hFFFFFFFF1F, 64'd0,          0, 3'd2);
        setv(5,  1'b0, 5, 80'hFFFFFFFF0F, 64'hFFFFFFFF,   5, 3'd0);
        setv(6,  1'b1, 5, 80'hFFFFFFFF7F, 64'hFFFFFFFF,   5, 3'd0);
        setv(7,  1'b1, 2, 80'h807F,       64'hFFFFFF80,   2, 3'd0);
        setv(8,  1'b1, 5, 80'hFFFFFFFF4F, 64'd0,          0, 3'd2);
        setv(9,  1'b0, 1, 80'h7F,         64'h7F,         1, 3'd0);
        setv(10, 1'b1, 3, 80'hE58E26,     64'd624485,     3, 3'd0);
        setv(11, 1'b1, 3, 80'hC0BB78,     64'hFFFE1DC0,   3, 3'd0);

        repeat (2) @(negedge clk);
        rst = 1'b0; rst6 = 1'b0;
        chk("rst_in_ready", 64'(ir), 64'd1);
        chk("rst_valid",    64'(rv), 64'd0);
        chk("rst_result",   64'(res), 64'd0);
        chk("rst_used",     64'(used), 64'd0);
        chk("rst_trap",     64'(trap), 64'd0);

        for (int k = 0; k < 12; k++) begin
            reset32();
            feed32(vt[k].sgn, vt[k].n, vt[k].bs);
            chk($sformatf("v%0d_trap", k), 64'(trap), 64'(vt[k].trap));
            chk($sformatf("v%0d_in_ready", k), 64'(ir), 64'd0);
            chk($sformatf("v%0d_valid", k), 64'(rv),
                (vt[k].trap == 3'd0) ? 64'd1 : 64'd0);
            if (vt[k].trap == 3'd0) begin
                chk($sformatf("v%0d_result", k), 64'(res), vt[k].res);
                chk($sformatf("v%0d_used", k), 64'(used),
                    64'(vt[k].used));
            end
        end

        // sticky error: more bytes and result_ready change nothing
        reset32();
        feed32(1'b0, 5, 80'h8080808080);
        @(negedge clk);
        iv = 1'b1; ib = 8'h05; rr = 1'b1;
        repeat (2) @(negedge clk);
        iv = 1'b0; rr = 1'b0;
        chk("sticky_trap",  64'(trap), 64'd1);
        chk("sticky_valid", 64'(rv), 64'd0);
        chk("sticky_ready", 64'(ir), 64'd0);

        // mode latched on byte 0, idle gap ignored, rr inert in ACCUM
        reset32();
        @(negedge clk);
        ib = 8'h80; iv = 1'b1; isg = 1'b0; rr = 1'b1;
        @(negedge clk);
        ib = 8'hFF; iv = 1'b0; isg = 1'b1; rr = 1'b1;
        @(negedge clk);
        ib = 8'h7F; iv = 1'b1; isg = 1'b1; rr = 1'b0;
        @(negedge clk);
        iv = 1'b0;
        chk("mode_result", 64'(res), 64'h3F80);
        chk("mode_used",   64'(used), 64'd2);
        chk("mode_valid",  64'(rv), 64'd1);

        // backpressure: held result, stray bytes ignored
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            iv = 1'b1; ib = 8'h01; rr = 1'b0;
            chk($sformatf("bp%0d_result", c), 64'(res), 64'h3F80);
            chk($sformatf("bp%0d_in_ready", c), 64'(ir), 64'd0);
            chk($sformatf("bp%0d_valid", c), 64'(rv), 64'd1);
        end
        iv = 1'b0; rr = 1'b1;
        @(negedge clk);
        rr = 1'b0;
        chk("bp_release_valid", 64'(rv), 64'd0);
        chk("bp_release_ready", 64'(ir), 64'd1);
        feed32(1'b0, 1, 80'h05);
        chk("bp_next_result", 64'(res), 64'd5);
        chk("bp_next_used",   64'(used), 64'd1);

        // reset in the middle of a value
        reset32();
        feed32(1'b0, 2, 80'h8080);
        reset32();
        chk("mid_rst_used", 64'(used), 64'd0);
        chk("mid_rst_ready", 64'(ir), 64'd1);
        feed32(1'b0, 1, 80'h05);
        chk("mid_result", 64'(res), 64'd5);
        chk("mid_used",   64'(used), 64'd1);
        chk("mid_trap",   64'(trap), 64'd0);
        chk("mid_valid",  64'(rv), 64'd1);

        // 64-bit instance
        reset64();
        feed64(1'b1, 10, 80'h8080808080808080807F);
        chk("w64_s_result", res6, 64'h8000000000000000);
        chk("w64_s_used",   64'(used6), 64'd10);
        chk("w64_s_trap",   64'(trap6), 64'd0);
        chk("w64_s_valid",  64'(rv6), 64'd1);

        reset64();
        feed64(1'b0, 10, 80'hFFFFFFFFFFFFFFFFFF01);
        chk("w64_u_result", res6, 64'hFFFFFFFFFFFFFFFF);
        chk("w64_u_used",   64'(used6), 64'd10);

        reset64();
        feed64(1'b0, 10, 80'hFFFFFFFFFFFFFFFFFF02);
        chk("w64_bad_trap", 64'(trap6), 64'd2);

        reset64();
        feed64(1'b0, 10, 80'h80808080808080808080);
        chk("w64_long_trap",  64'(trap6), 64'd1);
        chk("w64_long_ready", 64'(ir6), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
